mc_datapath: RTL and testbench
==============================

# mc_datapath

Multicycle MIPS datapath: the execution end of the multicycle control interface. It holds the PC, the instruction and data latches, the A/B/ALUOut non-architectural registers, the 32×32 register file and the ALU. It consumes the per-cycle control strobes and returns `op`, `funct` and `zero` to the controller. It sits between the controller and the unified instruction/data memory.

## Interface
- Parameters: none; widths are fixed at 32-bit data and 5-bit register index.
- Clocking: one clock; reset is synchronous and active-high.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `pcen` in 1: PC write enable.
- `irwrite` in 1: instruction register write enable.
- `iord` in 1: memory address select; 0 = PC, 1 = ALUOut.
- `pcsrc` in 2: next-PC select.
- `alucontrol` in 3: ALU operation.
- `alusrca` in 1: ALU A operand; 0 = PC, 1 = A register.
- `alusrcb` in 2: ALU B operand select.
- `regwrite` in 1: register file write enable.
- `regdst` in 1: destination register; 0 = rt `instr[20:16]`, 1 = rd `instr[15:11]`.
- `memtoreg` in 1: write-back source; 0 = ALUOut, 1 = Data register.
- `readdata` in 32: memory read data.
- `adr` out 32: memory address.
- `writedata` out 32: memory write data; this is the B register.
- `op` out 6: `instr[31:26]`.
- `funct` out 6: `instr[5:0]`.
- `zero` out 1: ALUResult == 0, combinational.

## Operation
- Registers updated every clock: Data ← `readdata`, A ← rf[rs], B ← rf[rt], ALUOut ← ALUResult.
- PC ← PCNext only when `pcen`; Instr ← `readdata` only when `irwrite`.
- `signimm` = sign-extended `instr[15:0]`.
- `alusrcb`: 00 = B, 01 = 32'd4, 10 = signimm, 11 = signimm<<2.
- `alucontrol` (all ops mod 2^32):
  - 000 AND, 001 OR, 010 ADD, 110 SUB
  - 111 SLT: signed compare, result 1 or 0
  - 011/100/101: result 0
- `pcsrc`: 00 = ALUResult, 01 = ALUOut, 10 = jump target (see Configuration), 11 = ALUResult.
- Register file:
  - Two combinational read ports (rs, rt) and one synchronous write port.
  - Writes of register 0 are discarded; reading register 0 returns 0.
  - No write-to-read bypass: a read in the same cycle as a write returns the old value.
- `adr` = `iord` ? ALUOut : PC.

## Timing
- Reset, synchronous: PC, Instr, Data, A, B, ALUOut and all 32 registers cleared to 0.
- Outputs one cycle after reset: `adr` = 0 (with `iord`=0), `op` = 0, `funct` = 0, `writedata` = 0, `zero` = 1 for ADD of 0+0.
- Reset asserted mid-instruction wins over `pcen`/`irwrite`/`regwrite` in that same edge; no partial state survives.
- Latency:
  - `readdata` reaches `op`/`funct` one edge after `irwrite`.
  - Register read reaches the ALU one edge later, via A/B.
  - ALUResult reaches ALUOut one edge later.
- `zero` is valid in the same cycle as the operands. The controller samples it combinationally to form `pcen` for BEQ/BNE.
- Simultaneous `pcen` and `irwrite` (fetch cycle): Instr captures `readdata` from the old PC; PC takes PC+4.
- Arithmetic wraps silently; no overflow flag is produced.

## Configuration
- `MC_JUMP_EN` defined:
  - `pcsrc`=10 selects {PC[31:28], `instr[25:0]`, 2'b00}, using the already-incremented PC.
- `MC_JUMP_EN` undefined:
  - `pcsrc`=10 selects the current PC, so the PC holds even with `pcen`=1.
  - The jump-address logic is absent.

## Structure
- Package `mips_mc_pkg` holds:
  - ALU control constants (`ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLT`)
  - `alusrcb` encodings (`SRCB_REG`, `SRCB_FOUR`, `SRCB_IMM`, `SRCB_IMMSH`)
  - `pcsrc` encodings (`PC_ALU`, `PC_ALUOUT`, `PC_JUMP`)
- The controller imports the same package.
- Sub-module `mc_regfile`: 32×32 storage, 2 read ports and 1 write port, r0 hardwired to zero, synchronous reset clear.
- ALU, multiplexers and pipeline registers are inline.

## Test plan
- Reset held 2 cycles, then released with all controls 0 → `adr`=0, `op`=0, `funct`=0, `writedata`=0, `zero`=1.
- Fetch: `readdata`=0x8C080004, `irwrite`=1, `pcen`=1, `alusrca`=0, `alusrcb`=01, ADD, `pcsrc`=00 → next cycle PC=4, `op`=6'h23, `adr`=4.
- R-type: r9=7 and r10=5 preloaded, Instr=0x012A4022 (SUB r8), `alusrca`=1, `alusrcb`=00, SUB, then `regwrite`=1, `regdst`=1, `memtoreg`=0 → r8=2; write to r0 with value 9 → r0 still reads 0.
- SLT signed: A=0xFFFFFFFF, B=1, `alucontrol`=111 → ALUOut=1; SUB with A=B=0x1234 → `zero`=1 in the same cycle.
- Branch target: PC=8, `instr[15:0]`=0xFFFE, `alusrcb`=11, ADD → ALUOut=0; then `pcsrc`=01, `pcen`=1 → PC=0.
- Jump: PC=0x40000004, `instr[25:0]`=0x0000010, `pcsrc`=10, `pcen`=1.
  - With `MC_JUMP_EN` → PC=0x40000040.
  - Without `MC_JUMP_EN` → PC unchanged at 0x40000004.
  - Reset asserted on the same edge → PC=0.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS controller and datapath.
// Also carries the ALU function so both ends agree on operation semantics.
package mips_mc_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Unused encodings produce 0; arithmetic wraps with no overflow flag.
  function automatic logic [31:0] alu_f(input logic [2:0]  ctl,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    case (ctl)
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write
// port, r0 reads as zero, no write-to-read bypass, synchronous clear.
module mc_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] mem_q [32];
  logic [31:0] mem_d [32];

  always_comb begin
    for (int i = 0; i < 32; i++) mem_d[i] = mem_q[i];
    if (we && (wa != 5'd0)) mem_d[wa] = wd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : mem_q[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : mem_q[ra2];

endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS datapath: PC, IR, MDR, A/B/ALUOut, register file and ALU.
// Define MC_JUMP_EN to enable the pcsrc=10 jump target; otherwise PC holds.
module mc_datapath
  import mips_mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        pcen,
  input  logic        irwrite,
  input  logic        iord,
  input  logic [1:0]  pcsrc,
  input  logic [2:0]  alucontrol,
  input  logic        alusrca,
  input  logic [1:0]  alusrcb,
  input  logic        regwrite,
  input  logic        regdst,
  input  logic        memtoreg,
  input  logic [31:0] readdata,
  output logic [31:0] adr,
  output logic [31:0] writedata,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        zero
);

  logic [31:0] pc_q, pc_d, instr_q, instr_d, data_q, data_d;
  logic [31:0] a_q, a_d, b_q, b_d, aluout_q, aluout_d;
  logic [31:0] rd1, rd2, signimm, srca, srcb, aluresult, pcjump, pcnext, wd;
  logic [4:0]  wa;

  mc_regfile u_rf (
    .clk   (clk),
    .reset (reset),
    .we    (regwrite),
    .ra1   (instr_q[25:21]),
    .ra2   (instr_q[20:16]),
    .wa    (wa),
    .wd    (wd),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  // PC already holds PC+4 when a jump executes, so its top nibble is used as-is.
`ifdef MC_JUMP_EN
  assign pcjump = {pc_q[31:28], instr_q[25:0], 2'b00};
`else
  assign pcjump = pc_q;
`endif

  always_comb begin
    signimm = {{16{instr_q[15]}}, instr_q[15:0]};
    srca    = alusrca ? a_q : pc_q;
    case (alusrcb)
      SRCB_REG:   srcb = b_q;
      SRCB_FOUR:  srcb = 32'd4;
      SRCB_IMM:   srcb = signimm;
      default:    srcb = {signimm[29:0], 2'b00};
    endcase
    aluresult = alu_f(alucontrol, srca, srcb);
    case (pcsrc)
      PC_ALUOUT: pcnext = aluout_q;
      PC_JUMP:   pcnext = pcjump;
      default:   pcnext = aluresult;
    endcase
    wa = regdst ? instr_q[15:11] : instr_q[20:16];
    wd = memtoreg ? data_q : aluout_q;
  end

  always_comb begin
    pc_d     = pcen ? pcnext : pc_q;
    instr_d  = irwrite ? readdata : instr_q;
    data_d   = readdata;
    a_d      = rd1;
    b_d      = rd2;
    aluout_d = aluresult;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= '0;
      instr_q  <= '0;
      data_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      data_q   <= data_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
    end
  end

  assign adr       = iord ? aluout_q : pc_q;
  assign writedata = b_q;
  assign op        = instr_q[31:26];
  assign funct     = instr_q[5:0];
  assign zero      = (aluresult == 32'd0);

endmodule

// File: tb/tb_mc_datapath.sv
// Directed-vector bench for mc_datapath; expected values are hand-derived.
module tb_mc_datapath;
  import mips_mc_pkg::*;

  logic        clk = 1'b0;
  logic        reset, pcen, irwrite, iord, alusrca, regwrite, regdst, memtoreg;
  logic [1:0]  pcsrc, alusrcb;
  logic [2:0]  alucontrol;
  logic [31:0] readdata, adr, writedata;
  logic [5:0]  op, funct;
  logic        zero;

  int n_cmp  = 0;
  int n_fail = 0;

  mc_datapath dut (
    .clk        (clk),
    .reset      (reset),
    .pcen       (pcen),
    .irwrite    (irwrite),
    .iord       (iord),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .regwrite   (regwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .readdata   (readdata),
    .adr        (adr),
    .writedata  (writedata),
    .op         (op),
    .funct      (funct),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Load IR, then let A/B capture the new rs/rt.
  task automatic load_instr(input logic [31:0] w);
    readdata = w; irwrite = 1'b1;
    tick();
    irwrite = 1'b0;
    tick();
  endtask

  // Write register r with value v through the Data-register write-back path.
  task automatic wr_reg(input logic [4:0] r, input logic [31:0] v);
    readdata = {11'd0, r, 16'd0}; irwrite = 1'b1;
    tick();
    irwrite = 1'b0; readdata = v;
    tick();
    regwrite = 1'b1; regdst = 1'b0; memtoreg = 1'b1;
    tick();
    regwrite = 1'b0; memtoreg = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pcen = 1'b0; irwrite = 1'b0; iord = 1'b0; alusrca = 1'b0;
    regwrite = 1'b0; regdst = 1'b0; memtoreg = 1'b0; pcsrc = 2'b00;
    alusrcb = 2'b00; alucontrol = 3'b000; readdata = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_adr", adr, 32'd0);
    chk("rst_op", 32'(op), 32'd0);
    chk("rst_funct", 32'(funct), 32'd0);
    chk("rst_wdata", writedata, 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);

    // Fetch: IR from PC=0, PC <- 0+4
    readdata = 32'h8C08_0004; irwrite = 1'b1; pcen = 1'b1;
    alusrcb = SRCB_FOUR; alucontrol = ALU_ADD; pcsrc = PC_ALU;
    tick();
    irwrite = 1'b0; pcen = 1'b0;
    chk("fetch_adr", adr, 32'd4);
    chk("fetch_op", 32'(op), 32'h23);
    chk("fetch_funct", 32'(funct), 32'h04);

    // Register preload; B captures old value on the write edge
    wr_reg(5'd9, 32'd7);
    chk("no_bypass", writedata, 32'd0);
    tick();
    chk("r9_read", writedata, 32'd7);
    wr_reg(5'd10, 32'd5);
    tick();
    chk("r10_read", writedata, 32'd5);

    // R-type SUB r8 = r9 - r10
    readdata = 32'h012A_4022; irwrite = 1'b1;
    tick();
    irwrite = 1'b0;
    chk("rtype_funct", 32'(funct), 32'h22);
    tick();
    alusrca = 1'b1; alusrcb = SRCB_REG; alucontrol = ALU_SUB;
    #1;
    chk("sub_zero0", 32'(zero), 32'd0);
    tick();
    iord = 1'b1; #1;
    chk("sub_aluout", adr, 32'd2);
    iord = 1'b0;
    regwrite = 1'b1; regdst = 1'b1; memtoreg = 1'b0;
    tick();
    regwrite = 1'b0; regdst = 1'b0;
    load_instr(32'h0008_0000);
    chk("r8_read", writedata, 32'd2);

    // Writes to r0 are discarded
    wr_reg(5'd0, 32'd9);
    tick();
    chk("r0_read", writedata, 32'd0);

    // ALU ops with A=0xFFFFFFFF, B=1
    wr_reg(5'd11, 32'hFFFF_FFFF);
    wr_reg(5'd12, 32'd1);
    load_instr(32'h016C_0000);
    chk("b_is_1", writedata, 32'd1);
    alusrca = 1'b1; alusrcb = SRCB_REG; iord = 1'b1;
    alucontrol = ALU_SLT; tick(); chk("slt_signed", adr, 32'd1);
    alucontrol = ALU_AND; tick(); chk("and", adr, 32'd1);
    alucontrol = ALU_OR;  tick(); chk("or", adr, 32'hFFFF_FFFF);
    alucontrol = ALU_SUB; tick(); chk("sub_neg", adr, 32'hFFFF_FFFE);
    alucontrol = 3'b011;  tick(); chk("op011", adr, 32'd0);
    alucontrol = ALU_ADD; #1;
    chk("add_wrap_zero", 32'(zero), 32'd1);
    tick(); chk("add_wrap", adr, 32'd0);
    iord = 1'b0;

    // zero is combinational on equal operands
    wr_reg(5'd13, 32'h0000_1234);
    load_instr(32'h01AD_0000);
    alusrca = 1'b1; alucontrol = ALU_SUB; #1;
    chk("sub_eq_zero", 32'(zero), 32'd1);

    // Branch target: PC=8, imm=-2
    alusrca = 1'b0; alusrcb = SRCB_FOUR; alucontrol = ALU_ADD; pcsrc = PC_ALU;
    pcen = 1'b1; tick(); pcen = 1'b0;
    chk("pc8", adr, 32'd8);
    load_instr(32'h0000_FFFE);
    alusrcb = SRCB_IMM; tick();
    iord = 1'b1; #1;
    chk("signimm", adr, 32'd6);
    alusrcb = SRCB_IMMSH; tick();
    chk("br_target", adr, 32'd0);
    iord = 1'b0; alusrcb = SRCB_FOUR; pcsrc = PC_ALUOUT; pcen = 1'b1;
    tick(); pcen = 1'b0;
    chk("pc_aluout", adr, 32'd0);
    pcsrc = 2'b11; pcen = 1'b1;
    tick(); pcen = 1'b0;
    chk("pc_src11", adr, 32'd4);

    // Jump from PC=0x40000004
    wr_reg(5'd14, 32'h4000_0004);
    load_instr(32'h01C0_0000);
    alusrca = 1'b1; alusrcb = SRCB_REG; alucontrol = ALU_ADD; pcsrc = PC_ALU;
    pcen = 1'b1; tick(); pcen = 1'b0; alusrca = 1'b0;
    chk("pc_set", adr, 32'h4000_0004);
    load_instr(32'h0000_0010);
    pcsrc = PC_JUMP; pcen = 1'b1; tick(); pcen = 1'b0;
`ifdef MC_JUMP_EN
    chk("jump", adr, 32'h4000_0040);
`else
    chk("jump_hold", adr, 32'h4000_0004);
`endif

    // Reset wins over pcen/irwrite/regwrite on the same edge
    reset = 1'b1; pcen = 1'b1; irwrite = 1'b1; regwrite = 1'b1;
    readdata = 32'h8C08_0004;
    tick();
    reset = 1'b0; pcen = 1'b0; irwrite = 1'b0; regwrite = 1'b0; pcsrc = PC_ALU;
    alusrcb = SRCB_REG; alucontrol = ALU_AND;
    chk("rst_pc", adr, 32'd0);
    chk("rst_op2", 32'(op), 32'd0);
    load_instr(32'h000E_0000);
    chk("rst_rf_clear", writedata, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
